// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encodings, oversample factor and
// the baud divisor formula that the matching transmitter also uses.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return int'((longint'(clk_hz) + longint'(os / 2) * longint'(baud)) /
                    (longint'(os) * longint'(baud)));
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bundle from uart_rx to the debug bridge, plus a state debug view.
interface uart_rx_if;
    import uart_rx_pkg::*;

    // rx_byte_valid is a one-cycle strobe with no ready: the consumer must take
    // rx_byte in the cycle the strobe is high. framing_error is a separate strobe
    // and never coincides with rx_byte_valid.
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       framing_error;
    logic       rx_busy;
    rx_state_e  state;

    modport master (
        output rx_byte_valid,
        output rx_byte,
        output framing_error,
        output rx_busy,
        output state
    );

    modport slave (
        input rx_byte_valid,
        input rx_byte,
        input framing_error,
        input rx_busy,
        input state
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by clear
// so ticks can be phase-aligned to a start edge.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 18432000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $fatal(1, "uart_baud_tick: clock too slow for BAUD, DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampling with a 3-sample majority vote
// taken at sample counts 7, 8 and 9 of each bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 18432000,
    parameter int BAUD   = 115200
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);

    logic       rx_meta_q;
    logic       rx_s_q;
    logic       tick;
    logic       tick_clear;

    rx_state_e  state_q,         state_d;
    logic [3:0] scnt_q,          scnt_d;
    logic [2:0] bit_idx_q,       bit_idx_d;
    logic [7:0] shreg_q,         shreg_d;
    logic [2:0] votes_q,         votes_d;
    logic [7:0] rx_byte_q,       rx_byte_d;
    logic       rx_byte_valid_q, rx_byte_valid_d;
    logic       framing_error_q, framing_error_d;
    logic       rx_busy_q,       rx_busy_d;
    logic       bit_vote;
    logic       stop_vote;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Restart the tick divider on the start edge so every vote lands mid-bit.
    assign tick_clear = (state_q == ST_IDLE) && !rx_s_q;

    uart_baud_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign bit_vote  = majority3(votes_q[0], votes_q[1], votes_q[2]);
    // The stop decision is made on the third vote's own tick, so use rx_s live.
    assign stop_vote = majority3(votes_q[0], votes_q[1], rx_s_q);

    always_comb begin
        state_d         = state_q;
        scnt_d          = scnt_q;
        bit_idx_d       = bit_idx_q;
        shreg_d         = shreg_q;
        votes_d         = votes_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        framing_error_d = 1'b0;

        if (tick && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)) begin
            scnt_d = scnt_q + 4'd1;
            case (scnt_q)
                4'd7:    votes_d[0] = rx_s_q;
                4'd8:    votes_d[1] = rx_s_q;
                4'd9:    votes_d[2] = rx_s_q;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    scnt_d  = 4'd0;
                end
            end
            ST_START: begin
                if (tick && scnt_q == 4'd15) begin
                    if (!bit_vote) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick && scnt_q == 4'd15) begin
                    shreg_d   = {bit_vote, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick && scnt_q == 4'd9) begin
                    if (stop_vote) begin
                        rx_byte_d       = shreg_q;
                        rx_byte_valid_d = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            scnt_q          <= 4'd0;
            bit_idx_q       <= 3'd0;
            shreg_q         <= 8'h00;
            votes_q         <= 3'b000;
            rx_byte_q       <= 8'h00;
            rx_byte_valid_q <= 1'b0;
            framing_error_q <= 1'b0;
            rx_busy_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            scnt_q          <= scnt_d;
            bit_idx_q       <= bit_idx_d;
            shreg_q         <= shreg_d;
            votes_q         <= votes_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            framing_error_q <= framing_error_d;
            rx_busy_q       <= rx_busy_d;
        end
    end

    assign bus.rx_byte_valid = rx_byte_valid_q;
    assign bus.rx_byte       = rx_byte_q;
    assign bus.framing_error = framing_error_q;
    assign bus.rx_busy       = rx_busy_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 18.432 MHz / 115200 baud (160 clocks per bit).
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CLK_HZ = 18432000;
    localparam int BAUD   = 115200;
    localparam int CPB    = 160;

    logic clk = 1'b0;
    logic reset;
    logic rx;

    uart_rx_if bus();

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    logic       busy_at_valid = 1'b1;
    logic [7:0] got_q[$];
    int         stamp_q[$];
    logic [7:0] exp_q[$];
    int         rd_idx = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.rx_byte_valid === 1'b1) begin
            got_q.push_back(bus.rx_byte);
            stamp_q.push_back(cyc);
            busy_at_valid = bus.rx_busy;
        end
        if (bus.framing_error === 1'b1) ferr_cnt++;
        if (bus.rx_byte_valid === 1'b1 && bus.framing_error === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int cpb);
        rx = b;
        idle(cpb);
    endtask

    task automatic send_frame(input logic [7:0] data, input int cpb, input logic stop);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(data[i], cpb);
        send_bit(stop, cpb);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, got_q.size(), rd_idx + exp_q.size());
        while (exp_q.size() > 0) begin
            check({tag, "_byte"}, got_q[rd_idx], exp_q.pop_front());
            rd_idx++;
        end
    endtask

    int n0;
    int nv;
    int busy_cycles;
    logic [7:0] partial;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        idle(5);
        check("rst_valid", bus.rx_byte_valid, 0);
        check("rst_ferr",  bus.framing_error, 0);
        check("rst_busy",  bus.rx_busy, 0);
        check("rst_byte",  bus.rx_byte, 8'h00);
        check("rst_state", bus.state, ST_IDLE);
        reset = 1'b0;
        idle(20);

        // Single byte
        send_frame(8'h01, CPB, 1'b1);
        idle(100);
        exp_q.push_back(8'h01);
        check_bytes("single");
        check("single_ferr", ferr_cnt, 0);
        check("single_busy_at_valid", busy_at_valid, 0);
        check("single_hold", bus.rx_byte, 8'h01);
        check("single_busy_after", bus.rx_busy, 0);

        // Back-to-back frames, no idle bits
        n0 = stamp_q.size();
        send_frame(8'h02, CPB, 1'b1);
        send_frame(8'hC0, CPB, 1'b1);
        send_frame(8'h00, CPB, 1'b1);
        idle(100);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h00);
        check_bytes("b2b");
        check("b2b_gap1", (stamp_q[n0+1] - stamp_q[n0] >= 1595) && (stamp_q[n0+1] - stamp_q[n0] <= 1605), 1);
        check("b2b_gap2", (stamp_q[n0+2] - stamp_q[n0+1] >= 1595) && (stamp_q[n0+2] - stamp_q[n0+1] <= 1605), 1);
        check("b2b_ferr", ferr_cnt, 0);

        // Glitch: 40 low cycles on an idle line
        nv = got_q.size();
        busy_cycles = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) busy_cycles++;
        end
        rx = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) busy_cycles++;
        end
        check("glitch_busy_len", (busy_cycles >= 150) && (busy_cycles <= 170), 1);
        check("glitch_no_pulse", got_q.size(), nv);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_state", bus.state, ST_IDLE);

        // Framing error then break, then recovery
        nv = got_q.size();
        send_frame(8'h55, CPB, 1'b0);
        idle(3200 - CPB);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_valid", got_q.size(), nv);
        check("ferr_busy_held", bus.rx_busy, 1);
        check("ferr_state", bus.state, ST_BREAK);
        check("ferr_byte_kept", bus.rx_byte, 8'h00);
        rx = 1'b1;
        idle(20);
        check("break_release_busy", bus.rx_busy, 0);
        send_frame(8'hA5, CPB, 1'b1);
        idle(100);
        exp_q.push_back(8'hA5);
        check_bytes("after_break");

        // Reset during bit 4 of 0x3C
        nv = got_q.size();
        partial = 8'h3C;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(partial[i], CPB);
        rx = partial[4];
        idle(80);
        reset = 1'b1;
        #1;
        check("midrst_valid", bus.rx_byte_valid, 0);
        check("midrst_ferr",  bus.framing_error, 0);
        check("midrst_busy",  bus.rx_busy, 0);
        check("midrst_byte",  bus.rx_byte, 8'h00);
        check("midrst_state", bus.state, ST_IDLE);
        rx = 1'b1;
        idle(5);
        reset = 1'b0;
        idle(200);
        check("midrst_no_pulse", got_q.size(), nv);
        send_frame(8'h3C, CPB, 1'b1);
        idle(100);
        exp_q.push_back(8'h3C);
        check_bytes("after_rst");
        check("after_rst_byte", bus.rx_byte, 8'h3C);

        // Baud skew +/-3%
        send_frame(8'h96, 165, 1'b1);
        idle(100);
        send_frame(8'h96, 155, 1'b1);
        idle(100);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h96);
        check_bytes("skew");
        check("skew_ferr", ferr_cnt, 1);
        check("no_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
